// File: rtl/led_tap_sampler.sv
// led_tap_sampler: shift-register tap sampler feeding a bank of status LEDs.
// Beats shift into sr; every P accepted beats the selected sr bits are latched
// onto led_o and led_stb_o pulses for one cycle.

// One LED lane: holds the latched value of a single tap.
module led_tap_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic upd,
    input  logic tap_bit,
    output logic led
);
    // Latch the tap on an updating wrap; clear wins over update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       led <= 1'b0;
        else if (clear_i) led <= 1'b0;
        else if (upd)     led <= tap_bit;
    end
endmodule

module led_tap_sampler #(
    parameter int                 DATA_W = 8,
    parameter int                 SR_W   = 16,
    parameter int                 LED_N  = 3,
    parameter int                 CNT_W  = 8,
    parameter logic [LED_N*8-1:0] TAPS   = {8'd15, 8'd8, 8'd0}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic              freeze_i,
    input  logic              clear_i,
    output logic [LED_N-1:0]  led_o,
    output logic              led_stb_o,
    output logic [SR_W-1:0]   sr_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Elaboration-time sanity checks on the geometry.
    if (SR_W <= DATA_W) begin : g_bad_width
        $error("led_tap_sampler: SR_W (%0d) must exceed DATA_W (%0d)", SR_W, DATA_W);
    end
    for (genvar i = 0; i < LED_N; i++) begin : g_chk_tap
        if (int'(TAPS[8*i+:8]) >= SR_W) begin : g_bad_tap
            $error("led_tap_sampler: tap %0d index %0d out of range", i, TAPS[8*i+:8]);
        end
    end

    logic [SR_W-1:0]  sr, sr_next;
    logic [CNT_W-1:0] cnt, p_eff;
    logic             accept, wrap, upd;
    logic [LED_N-1:0] tap_bits;

    // Next shift value, effective period and wrap decision for this cycle.
    always_comb begin
        sr_next = {sr[SR_W-DATA_W-1:0], data_i};
        p_eff   = (period_i == '0) ? ONE : period_i;
        accept  = in_valid & ~clear_i;
        // >= so a period shrunk below the running count wraps on the next beat.
        wrap    = accept & (cnt >= (p_eff - ONE));
        upd     = wrap & ~freeze_i;
    end

    // Shift register and modulo-P beat counter; clear beats any incoming beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear_i) begin
            sr  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sr  <= sr_next;
            cnt <= wrap ? '0 : cnt + ONE;
        end
    end

    // Strobe is the registered update flag: one cycle after the wrapping beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_stb_o <= 1'b0;
        else        led_stb_o <= upd;
    end

    // Per-lane tap selection; taps come from sr_next so the current beat counts.
    for (genvar i = 0; i < LED_N; i++) begin : g_lane
        localparam int TI = int'(TAPS[8*i+:8]);
        assign tap_bits[i] = sr_next[TI];
        led_tap_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (clear_i),
            .upd     (upd),
            .tap_bit (tap_bits[i]),
            .led     (led_o[i])
        );
    end

    assign sr_o = sr;
endmodule

// File: tb/tb_led_tap_sampler.sv
// tb_led_tap_sampler: directed scenarios plus randomized traffic checked
// against a beat-level reference model of the sampler.
module tb_led_tap_sampler;
    localparam int DATA_W = 8, SR_W = 16, LED_N = 3, CNT_W = 8;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              in_valid = 1'b0, freeze_i = 1'b0, clear_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic [CNT_W-1:0]  period_i = 8'd1;
    logic [LED_N-1:0]  led_o;
    logic              led_stb_o;
    logic [SR_W-1:0]   sr_o;

    led_tap_sampler dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_i(data_i),
        .period_i(period_i), .freeze_i(freeze_i), .clear_i(clear_i),
        .led_o(led_o), .led_stb_o(led_stb_o), .sr_o(sr_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Reference state: sr contents, beats accepted since last wrap, LED value, strobe.
    int unsigned m_sr = 0, m_since = 0, m_led = 0;
    bit          m_stb = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned taps_of(input int unsigned s);
        int unsigned idx[3] = '{0, 8, 15};
        int unsigned r = 0;
        for (int i = 0; i < LED_N; i++) r |= ((s >> idx[i]) & 1) << i;
        return r;
    endfunction

    function automatic void m_reset();
        m_sr = 0; m_since = 0; m_led = 0; m_stb = 0;
    endfunction

    // One clock: drive on negedge, advance model at posedge, compare 1 time unit later.
    task automatic cyc(input bit v, input logic [7:0] d, input logic [7:0] p,
                       input bit fr, input bit cl);
        int unsigned P;
        @(negedge clk);
        in_valid = v; data_i = d; period_i = p; freeze_i = fr; clear_i = cl;
        @(posedge clk);
        P = (p == 0) ? 1 : p;
        m_stb = 0;
        if (cl) begin
            m_sr = 0; m_since = 0; m_led = 0;
        end else if (v) begin
            m_sr = ((m_sr << 8) | d) & 32'hFFFF;
            m_since++;
            if (m_since >= P) begin
                m_since = 0;
                if (!fr) begin
                    m_led = taps_of(m_sr);
                    m_stb = 1;
                end
            end
        end
        #1;
        chk("sr", 32'(sr_o), m_sr);
        chk("led", 32'(led_o), m_led);
        chk("stb", 32'(led_stb_o), 32'(m_stb));
    endtask

    // Assert reset between edges and confirm outputs clear without a clock edge.
    task automatic async_rst();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sr", 32'(sr_o), 0);
        chk("rst_led", 32'(led_o), 0);
        chk("rst_stb", 32'(led_stb_o), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit v, fr, cl;
        logic [7:0] p;
        // Power-on reset.
        repeat (2) @(negedge clk);
        chk("por_sr", 32'(sr_o), 0);
        chk("por_led", 32'(led_o), 0);
        chk("por_stb", 32'(led_stb_o), 0);
        rst_n = 1'b1;

        // Period 2: A5 then 3C.
        cyc(1, 8'hA5, 2, 0, 0);
        chk("p2_nostb", 32'(led_stb_o), 0);
        cyc(1, 8'h3C, 2, 0, 0);
        chk("p2_sr", 32'(sr_o), 32'hA53C);
        chk("p2_led", 32'(led_o), 3'b110);
        chk("p2_stb", 32'(led_stb_o), 1);
        cyc(0, 8'h00, 2, 0, 0);
        chk("p2_stb_once", 32'(led_stb_o), 0);

        // Period 0 behaves as 1: update every beat.
        cyc(1, 8'h01, 0, 0, 0);
        chk("p0_led1", 32'(led_o), 3'b001);
        chk("p0_stb1", 32'(led_stb_o), 1);
        cyc(1, 8'h00, 0, 0, 0);
        chk("p0_led2", 32'(led_o), 3'b010);
        chk("p0_stb2", 32'(led_stb_o), 1);

        // Period 8 for 5 beats, then shrink to 3: wrap on 6th, then every 3.
        for (int i = 0; i < 5; i++) cyc(1, 8'(i + 1), 8, 0, 0);
        cyc(1, 8'h66, 3, 0, 0);
        chk("shrink_wrap6", 32'(led_stb_o), 1);
        cyc(1, 8'h77, 3, 0, 0);
        chk("shrink_b7", 32'(led_stb_o), 0);
        cyc(1, 8'h88, 3, 0, 0);
        cyc(1, 8'h99, 3, 0, 0);
        chk("shrink_wrap9", 32'(led_stb_o), 1);

        // Freeze across a wrap, then resume.
        cyc(1, 8'hFF, 2, 0, 0);
        cyc(1, 8'h00, 2, 1, 0);
        chk("frz_led_hold", 32'(led_o), 32'(taps_of(32'h8899)));
        chk("frz_nostb", 32'(led_stb_o), 0);
        cyc(1, 8'h81, 2, 0, 0);
        chk("frz_cnt0", 32'(led_stb_o), 0);
        cyc(1, 8'h01, 2, 0, 0);
        chk("frz_resume", 32'(led_stb_o), 1);
        chk("frz_resume_led", 32'(led_o), 3'b111);

        // Clear dominates a simultaneous beat; gaps hold state.
        cyc(1, 8'hFF, 2, 0, 1);
        chk("clr_sr", 32'(sr_o), 0);
        chk("clr_led", 32'(led_o), 0);
        cyc(0, 8'h12, 2, 0, 0);
        cyc(0, 8'h34, 2, 0, 0);
        cyc(1, 8'h80, 2, 0, 0);
        chk("clr_cnt0", 32'(led_stb_o), 0);
        cyc(1, 8'h80, 2, 0, 0);
        chk("clr_wrap", 32'(led_stb_o), 1);

        // Mid-period async reset; first wrap after release is on the P-th beat.
        cyc(1, 8'h01, 3, 0, 0);
        async_rst();

        // Randomized traffic.
        p = 8'(($urandom % 5));
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) p = 8'($urandom_range(0, 5));
            v  = ($urandom_range(0, 9) < 7);
            fr = ($urandom_range(0, 4) == 0);
            cl = ($urandom_range(0, 29) == 0);
            cyc(v, 8'($urandom), p, fr, cl);
            if ($urandom_range(0, 99) == 0) async_rst();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
